// File: rtl/serial_tx_pkg.sv
// Shared definitions for the asynchronous serial link: FSM state encoding,
// line idle level and a frame-length helper. Parity option: TX_PARITY_EN.
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  // Mark level of the line; the receiver treats this as "no frame".
  localparam logic LINE_IDLE = 1'b1;

  function automatic int unsigned frame_len(input int unsigned data_w,
                                            input int unsigned clks_per_bit,
                                            input int unsigned stop_bits);
    int unsigned p;
`ifdef TX_PARITY_EN
    p = 1;
`else
    p = 0;
`endif
    return (1 + data_w + p + stop_bits) * clks_per_bit;
  endfunction

endpackage

// File: rtl/serial_tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1, flags the last cycle of each
// period and reloads to zero on restart so every state starts a full period.
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic restart_i,
  output logic tc_o
);

  localparam int W = $clog2(CLKS_PER_BIT);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign tc_o = (count_q == W'(CLKS_PER_BIT - 1));

  always_comb begin
    count_d = count_q + 1'b1;
    if (restart_i || tc_o) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/serial_tx.sv
// Parallel-to-serial frame transmitter: start, DATA_W bits LSB first,
// optional even parity (TX_PARITY_EN), STOP_BITS stop periods.
module serial_tx
  import serial_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              tx_q, tx_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;
  logic              accept;
  logic              timer_tc;
  logic              timer_restart;
`ifdef TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  assign accept        = in_valid && in_ready_q;
  assign timer_restart = (state_d != state_q);

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk       (clk),
    .reset     (reset),
    .restart_i (timer_restart),
    .tc_o      (timer_tc)
  );

  // bit_cnt_q indexes data bits in DATA and stop periods in STOP.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
`ifdef TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = START;
          shift_d = in_data;
`ifdef TX_PARITY_EN
          parity_d = ^in_data;
`endif
        end
      end
      START: begin
        if (timer_tc) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (timer_tc) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
`ifdef TX_PARITY_EN
            state_d   = PARITY;
`else
            state_d   = STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
`ifdef TX_PARITY_EN
      PARITY: begin
        if (timer_tc) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (timer_tc) begin
          if (bit_cnt_q == LAST_STOP) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The line is a registered copy of the current state's level, which places
  // the falling start edge one clock after the handshake edge.
  always_comb begin
    tx_d = LINE_IDLE;
    case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[0];
`ifdef TX_PARITY_EN
      PARITY:  tx_d = parity_q;
`endif
      default: tx_d = LINE_IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      tx_q       <= LINE_IDLE;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_q       <= tx_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
    end
  end

`ifdef TX_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

  assign tx       = tx_q;
  assign in_ready = in_ready_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx (DATA_W=8, CLKS_PER_BIT=4); a second instance
// with STOP_BITS=2 covers the long stop period. Honours TX_PARITY_EN.
module tb_serial_tx;

`ifdef TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NBITS   = 1 + 8 + PB + 1;
  localparam int FR_CLKS = NBITS * 4;
  localparam int FR2     = FR_CLKS + 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready, tx, busy;
  logic [7:0] in_data2 = 8'h00;
  logic       in_valid2 = 1'b0;
  logic       in_ready2, tx2, busy2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .STOP_BITS(1)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .tx(tx), .busy(busy)
  );

  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .STOP_BITS(2)) dut2 (
    .clk(clk), .reset(reset), .in_data(in_data2), .in_valid(in_valid2),
    .in_ready(in_ready2), .tx(tx2), .busy(busy2)
  );

  // Expected line level for bit slot idx of a frame carrying d.
  function automatic logic exp_bit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (PB == 1 && idx == 9) return ^d;
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    in_valid = 1'b0;
    repeat (3) tick();
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL rst_tx got=%b exp=1", tx); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", in_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    reset = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      checks++;
      if (tx !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0) begin
        failures++;
        $display("FAIL idle_quiet cyc=%0d tx=%b ready=%b busy=%b exp tx=1 ready=1 busy=0", k, tx, in_ready, busy);
      end
    end
    $display("reset: done, checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_single_a5();
    logic [0:NBITS-1] pat;
`ifdef TX_PARITY_EN
    pat = 11'b01010010101;
`else
    pat = 10'b0101001011;
`endif
    in_data = 8'hA5;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_data = 8'h00;
    checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL a5_accept ready=%b busy=%b exp ready=0 busy=1", in_ready, busy); end
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL a5_latency tx=%b exp=1", tx); end
    for (int k = 1; k <= FR_CLKS; k++) begin
      tick();
      checks++;
      if (tx !== pat[(k-1)/4]) begin
        failures++;
        $display("FAIL a5_tx cyc=%0d got=%b exp=%b", k, tx, pat[(k-1)/4]);
      end
      checks++;
      if (in_ready !== (k == FR_CLKS)) begin
        failures++;
        $display("FAIL a5_ready cyc=%0d got=%b exp=%b", k, in_ready, (k == FR_CLKS));
      end
    end
    tick();
    checks++; if (tx !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL a5_end tx=%b busy=%b exp tx=1 busy=0", tx, busy); end
    $display("single A5: frame_clks=%0d checks=%0d failures=%0d", FR_CLKS, checks, failures);
  endtask

  task automatic test_back_to_back();
    in_data = 8'h00;
    in_valid = 1'b1;
    tick();
    in_data = 8'hFF;
    for (int k = 1; k <= FR_CLKS; k++) begin
      tick();
      checks++;
      if (tx !== exp_bit(8'h00, (k-1)/4)) begin
        failures++;
        $display("FAIL b2b_f1 cyc=%0d got=%b exp=%b", k, tx, exp_bit(8'h00, (k-1)/4));
      end
    end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_up got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL b2b_gap got=%b exp=1", tx); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_second_accept ready=%b exp=0", in_ready); end
    for (int k = 1; k <= FR_CLKS; k++) begin
      tick();
      checks++;
      if (tx !== exp_bit(8'hFF, (k-1)/4)) begin
        failures++;
        $display("FAIL b2b_f2 cyc=%0d got=%b exp=%b", k, tx, exp_bit(8'hFF, (k-1)/4));
      end
    end
    tick();
    checks++; if (busy !== 1'b0 || tx !== 1'b1) begin failures++; $display("FAIL b2b_end busy=%b tx=%b exp busy=0 tx=1", busy, tx); end
    $display("back-to-back 00,FF: checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_busy_ignore();
    in_data = 8'hA5;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= FR_CLKS; k++) begin
      if (k == 12) begin in_valid = 1'b1; in_data = 8'h3C; end
      if (k == 16) in_valid = 1'b0;
      tick();
      checks++;
      if (tx !== exp_bit(8'hA5, (k-1)/4)) begin
        failures++;
        $display("FAIL ignore_tx cyc=%0d got=%b exp=%b", k, tx, exp_bit(8'hA5, (k-1)/4));
      end
    end
    for (int k = 0; k < 30; k++) begin
      tick();
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL ignore_extra cyc=%0d tx=%b busy=%b ready=%b exp tx=1 busy=0 ready=1", k, tx, busy, in_ready);
      end
    end
    $display("busy ignore 3C: checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_frame_01();
    in_data = 8'h01;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= FR_CLKS; k++) begin
      tick();
      checks++;
      if (tx !== exp_bit(8'h01, (k-1)/4)) begin
        failures++;
        $display("FAIL f01_tx cyc=%0d got=%b exp=%b", k, tx, exp_bit(8'h01, (k-1)/4));
      end
    end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL f01_ready got=%b exp=1", in_ready); end
    tick();
    $display("frame 01 (parity slots=%0d): checks=%0d failures=%0d", PB, checks, failures);
  endtask

  task automatic test_reset_mid_frame();
    in_data = 8'h5A;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 14; k++) tick();
    checks++; if (tx !== 1'b0) begin failures++; $display("FAIL midrst_pre got=%b exp=0", tx); end
    #2 reset = 1'b0;
    #1;
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL midrst_async_tx got=%b exp=1", tx); end
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL midrst_flags ready=%b busy=%b exp ready=1 busy=0", in_ready, busy); end
    #2 reset = 1'b1;
    for (int k = 0; k < 50; k++) begin
      tick();
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL midrst_replay cyc=%0d tx=%b busy=%b ready=%b exp tx=1 busy=0 ready=1", k, tx, busy, in_ready);
      end
    end
    $display("reset mid-frame: checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_two_stop();
    in_data2 = 8'hA5;
    in_valid2 = 1'b1;
    tick();
    in_valid2 = 1'b0;
    for (int k = 1; k <= FR2; k++) begin
      tick();
      checks++;
      if (tx2 !== exp_bit(8'hA5, (k-1)/4)) begin
        failures++;
        $display("FAIL stop2_tx cyc=%0d got=%b exp=%b", k, tx2, exp_bit(8'hA5, (k-1)/4));
      end
      checks++;
      if (in_ready2 !== (k == FR2)) begin
        failures++;
        $display("FAIL stop2_ready cyc=%0d got=%b exp=%b", k, in_ready2, (k == FR2));
      end
    end
    tick();
    checks++; if (busy2 !== 1'b0 || tx2 !== 1'b1) begin failures++; $display("FAIL stop2_end busy=%b tx=%b exp busy=0 tx=1", busy2, tx2); end
    $display("two stop bits A5: frame_clks=%0d checks=%0d failures=%0d", FR2, checks, failures);
  endtask

  initial begin
    test_reset();
    test_single_a5();
    test_back_to_back();
    test_busy_ignore();
    test_frame_01();
    test_reset_mid_frame();
    test_two_stop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_tx.md
Name: serial_tx

Overview:
Parallel-to-serial frame transmitter. It is the transmit end of the team's asynchronous serial link and pairs with the existing serial receiver. It accepts one data word per valid/ready handshake and shifts it out on a single line: start bit, data LSB first, optional parity, stop bit(s). It sits between the core-side word producer and the pad-level serial line.

Parameters:
DATA_W, 8, data bits per frame (1..16)
CLKS_PER_BIT, 4, clk cycles per serial bit period (>= 2)
STOP_BITS, 1, number of stop bit periods (1 or 2)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
in_data  input  DATA_W  word to transmit; sampled only at handshake
in_valid  input  1  producer has a word
in_ready  output  1  transmitter can accept; high only in IDLE
tx  output  1  serial line, idle/mark level = 1
busy  output  1  frame in progress (any state other than IDLE)

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, tx=1, in_ready=1, busy=0, shift register and counters=0.
- Reset mid-frame: the line returns to 1 immediately and the frame is dropped. No partial replay after release.
- Handshake: a word is accepted on a rising clk when in_valid=1 and in_ready=1. in_data is latched into the shift register on that edge. Later in_data changes are ignored.
- in_valid while busy: ignored, no acceptance, no error. in_valid may drop without penalty while in_ready=0.
- State machine: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - IDLE: tx=1. Goes to START on handshake.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: tx=shift_reg[0]. Shift right every CLKS_PER_BIT cycles. Leave after DATA_W bits (bit counter 0..DATA_W-1).
  - PARITY: present only when the parity option is enabled; one bit period.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles, then IDLE.
- Bit timer: counts 0..CLKS_PER_BIT-1. Reloads to 0 on every state entry. Advances on terminal count, with no drift across bits.
- Latency: tx first goes low on the first clk edge after the handshake edge.
- Frame length: (1 + DATA_W + P + STOP_BITS) * CLKS_PER_BIT cycles, where P = 1 with the parity option, else 0.
- in_ready and busy are registered outputs. in_ready rises on the edge that ends the final stop cycle.
- Back-to-back: if in_valid is held high, the next handshake happens on the first IDLE cycle. The inter-frame gap is exactly 1 clk of tx=1 beyond the stop bits.
- Counter widths: $clog2(CLKS_PER_BIT) for the bit timer and $clog2(DATA_W+1) for the bit counter. No wrap outside the defined ranges.

Optional Feature:
TX_PARITY_EN
- Defined: an even-parity bit (XOR of the latched data word) is sent in the PARITY state, between the last data bit and the stop bits. The parity value is computed at the handshake.
- Undefined: the PARITY state and parity logic are absent, DATA goes directly to STOP, and P=0.

Decomposition:
- Package serial_pkg holds:
  - state encoding constants: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, in a 3-bit type;
  - the idle line-level constant (1), shared with the receiver;
  - a frame-length function of DATA_W, CLKS_PER_BIT and STOP_BITS, for benches.
- One sub-module is natural: bit_timer, a parameterised CLKS_PER_BIT counter with a restart input and a terminal-count output, reusable by the receiver.

Test Plan:
1. Reset check: hold reset=0 for 3 clk, then release -> tx=1, in_ready=1, busy=0. No transitions on tx for 20 clk with in_valid=0.
2. Single frame, DATA_W=8, CLKS_PER_BIT=4: send 8'hA5 -> tx holds 0,1,0,1,0,0,1,0,1,1 for 4 clk each, 40 clk total. in_ready low for those 40 clk and high on the next edge.
3. Back-to-back: 8'h00 then 8'hFF with in_valid held -> the second start bit begins exactly 1 clk after the first frame's stop bit ends. Each frame's data matches its input.
4. Busy ignore: pulse in_valid with 8'h3C mid-frame -> no acceptance, the current frame is unchanged, and no extra frame is sent afterwards.
5. Reset mid-frame: assert reset during the 3rd data bit -> tx=1 asynchronously, before the next clk edge. After release: IDLE, in_ready=1, and nothing is retransmitted.
6. With TX_PARITY_EN: 8'hA5 -> parity bit 0. 8'h01 -> parity bit 1. Frame grows to 44 clk. STOP_BITS=2 variant -> stop high for 8 clk.
